// File: rtl/jtopl_eg_seq.sv
// Per-slot envelope settings store and slot sequencer feeding EG stage I.
// CPU writes use a req/ack handshake; key-on changes take effect at frame start.
module jtopl_eg_seq #(
    parameter int SLOTS    = 18,
    parameter int CHANNELS = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cenop,
    input  logic       zero,
    input  logic       wr_req,
    input  logic [4:0] wr_slot,
    input  logic [2:0] wr_field,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    output logic       wr_err,
    input  logic       kon_req,
    input  logic [3:0] kon_ch,
    input  logic       kon_val,
    output logic [4:0] slot_I,
    output logic [3:0] arate_I,
    output logic [3:0] drate_I,
    output logic [3:0] rrate_I,
    output logic [3:0] sl_I,
    output logic       en_sus_I,
    output logic       ksr_I,
    output logic       keyon_I
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACK  = 1'b1;

    // Entry layout: {arate, drate, sl, rrate, ksr, en_sus}
    logic [17:0]         mem [SLOTS];
    logic [4:0]          idx;
    logic [4:0]          next_idx;
    logic [0:0]          state;
    logic                err_flag;
    logic                wr_ok;
    logic [CHANNELS-1:0] kon_pend;
    logic [CHANNELS-1:0] kon_act;
    logic [CHANNELS-1:0] kon_act_nxt;

    function automatic logic [3:0] slot_ch(input logic [4:0] s);
        return (s < 5'(CHANNELS)) ? s[3:0] : 4'(s - 5'(CHANNELS));
    endfunction

    always_comb begin
        next_idx = 5'd0;
        if (!zero && idx != 5'(SLOTS - 1))
            next_idx = idx + 5'd1;
    end

    // The slot starting a new frame must already see the freshly loaded key state
    always_comb begin
        kon_act_nxt = kon_act;
        if (next_idx == 5'd0)
            kon_act_nxt = kon_pend;
    end

    assign wr_ok  = (wr_slot < 5'(SLOTS)) && (wr_field < 3'd3);
    assign wr_ack = (state == ACK);
    assign wr_err = (state == ACK) && err_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= 5'(SLOTS - 1);
            slot_I   <= '0;
            arate_I  <= '0;
            drate_I  <= '0;
            sl_I     <= '0;
            rrate_I  <= '0;
            ksr_I    <= 1'b0;
            en_sus_I <= 1'b0;
            keyon_I  <= 1'b0;
            kon_act  <= '0;
        end else if (cenop) begin
            idx      <= next_idx;
            slot_I   <= next_idx;
            arate_I  <= mem[next_idx][17:14];
            drate_I  <= mem[next_idx][13:10];
            sl_I     <= mem[next_idx][9:6];
            rrate_I  <= mem[next_idx][5:2];
            ksr_I    <= mem[next_idx][1];
            en_sus_I <= mem[next_idx][0];
            keyon_I  <= kon_act_nxt[slot_ch(next_idx)];
            kon_act  <= kon_act_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kon_pend <= '0;
        end else if (kon_req && kon_ch < 4'(CHANNELS)) begin
            kon_pend[kon_ch] <= kon_val;
        end
    end

    // Commits are held off during cenop cycles so storage never changes while being read out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++)
                mem[i] <= '0;
            state    <= IDLE;
            err_flag <= 1'b0;
        end else if (state == IDLE) begin
            if (wr_req && !cenop) begin
                state    <= ACK;
                err_flag <= !wr_ok;
                if (wr_ok) begin
                    case (wr_field)
                        3'd0:    mem[wr_slot][17:10] <= wr_data;
                        3'd1:    mem[wr_slot][9:2]   <= wr_data;
                        3'd2:    mem[wr_slot][1:0]   <= wr_data[1:0];
                        default: ;
                    endcase
                end
            end
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_jtopl_eg_seq.sv
// Directed bench for jtopl_eg_seq: slot sequencing, CPU writes, key scheduling and reset.
module tb_jtopl_eg_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cenop, zero;
    logic       wr_req;
    logic [4:0] wr_slot;
    logic [2:0] wr_field;
    logic [7:0] wr_data;
    logic       wr_ack, wr_err;
    logic       kon_req;
    logic [3:0] kon_ch;
    logic       kon_val;
    logic [4:0] slot_I;
    logic [3:0] arate_I, drate_I, rrate_I, sl_I;
    logic       en_sus_I, ksr_I, keyon_I;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of the slot counter and key scheduling
    int         m_idx;
    logic [8:0] m_pend;
    logic [8:0] m_act;

    jtopl_eg_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cenop    (cenop),
        .zero     (zero),
        .wr_req   (wr_req),
        .wr_slot  (wr_slot),
        .wr_field (wr_field),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .wr_err   (wr_err),
        .kon_req  (kon_req),
        .kon_ch   (kon_ch),
        .kon_val  (kon_val),
        .slot_I   (slot_I),
        .arate_I  (arate_I),
        .drate_I  (drate_I),
        .rrate_I  (rrate_I),
        .sl_I     (sl_I),
        .en_sus_I (en_sus_I),
        .ksr_I    (ksr_I),
        .keyon_I  (keyon_I)
    );

    always #5 clk = ~clk;

    function automatic int ch_of(input int s);
        return (s < 9) ? s : s - 9;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic z);
        cenop = ce;
        zero  = z;
        @(posedge clk);
        #1;
        cenop   = 1'b0;
        zero    = 1'b0;
        kon_req = 1'b0;
    endtask

    task automatic opStep(input logic z);
        logic exp_key;
        m_idx = z ? 0 : ((m_idx == 17) ? 0 : m_idx + 1);
        if (m_idx == 0)
            m_act = m_pend;
        if (kon_req && kon_ch < 4'd9)
            m_pend[kon_ch] = kon_val;
        exp_key = m_act[ch_of(m_idx)];
        applyStimulus(1'b1, z);
        checkOutput("slot_I", {3'b0, slot_I}, 8'(m_idx));
        checkOutput("keyon_I", {7'b0, keyon_I}, {7'b0, exp_key});
    endtask

    task automatic doWrite(input logic [4:0] s, input logic [2:0] f, input logic [7:0] d,
                           input logic exp_err);
        wr_req   = 1'b1;
        wr_slot  = s;
        wr_field = f;
        wr_data  = d;
        applyStimulus(1'b0, 1'b0);
        checkOutput("wr_ack_pulse", {7'b0, wr_ack}, 8'd1);
        checkOutput("wr_err", {7'b0, wr_err}, {7'b0, exp_err});
        wr_req = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("wr_ack_end", {7'b0, wr_ack}, 8'd0);
    endtask

    task automatic doKon(input logic [3:0] ch, input logic v);
        kon_req = 1'b1;
        kon_ch  = ch;
        kon_val = v;
        if (ch < 4'd9)
            m_pend[ch] = v;
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic checkFields(input logic [3:0] a, input logic [3:0] d, input logic [3:0] s,
                               input logic [3:0] r, input logic k, input logic e);
        checkOutput("arate_I", {4'b0, arate_I}, {4'b0, a});
        checkOutput("drate_I", {4'b0, drate_I}, {4'b0, d});
        checkOutput("sl_I", {4'b0, sl_I}, {4'b0, s});
        checkOutput("rrate_I", {4'b0, rrate_I}, {4'b0, r});
        checkOutput("ksr_I", {7'b0, ksr_I}, {7'b0, k});
        checkOutput("en_sus_I", {7'b0, en_sus_I}, {7'b0, e});
    endtask

    task automatic resetModel();
        m_idx  = 17;
        m_pend = '0;
        m_act  = '0;
    endtask

    initial begin
        rst_n = 1'b0; cenop = 1'b0; zero = 1'b0;
        wr_req = 1'b0; wr_slot = '0; wr_field = '0; wr_data = '0;
        kon_req = 1'b0; kon_ch = '0; kon_val = 1'b0;
        resetModel();

        // Reset held while cenop keeps running
        repeat (4) applyStimulus(1'b1, 1'b0);
        checkOutput("rst_slot_I", {3'b0, slot_I}, 8'd0);
        checkFields(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("rst_keyon", {7'b0, keyon_I}, 8'd0);
        checkOutput("rst_wr_ack", {7'b0, wr_ack}, 8'd0);
        checkOutput("rst_wr_err", {7'b0, wr_err}, 8'd0);

        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 19; i++) opStep(1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("slot_hold", {3'b0, slot_I}, 8'd0);

        // Three field writes to slot 5
        doWrite(5'd5, 3'd0, 8'hA3, 1'b0);
        doWrite(5'd5, 3'd1, 8'h7C, 1'b0);
        doWrite(5'd5, 3'd2, 8'h03, 1'b0);
        while (m_idx != 5) opStep(1'b0);
        checkFields(4'hA, 4'h3, 4'h7, 4'hC, 1'b1, 1'b1);
        opStep(1'b0);
        checkFields(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

        // Request raised on a cenop cycle commits one cycle later
        wr_req = 1'b1; wr_slot = 5'd6; wr_field = 3'd0; wr_data = 8'h5A;
        opStep(1'b0);
        checkOutput("defer_no_ack", {7'b0, wr_ack}, 8'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("defer_ack", {7'b0, wr_ack}, 8'd1);
        checkOutput("defer_err", {7'b0, wr_err}, 8'd0);
        wr_req = 1'b0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("defer_ack_end", {7'b0, wr_ack}, 8'd0);

        doWrite(5'd20, 3'd0, 8'hFF, 1'b1);
        doWrite(5'd5, 3'd3, 8'hFF, 1'b1);
        while (m_idx != 5) opStep(1'b0);
        checkFields(4'hA, 4'h3, 4'h7, 4'hC, 1'b1, 1'b1);
        opStep(1'b0);
        checkFields(4'h5, 4'hA, 4'h0, 4'h0, 1'b0, 1'b0);

        // Key-on mid-frame reaches both slots of channel 2 only next frame
        doKon(4'd2, 1'b1);
        for (int i = 0; i < 23; i++) opStep(1'b0);
        checkOutput("keyon_s11", {7'b0, keyon_I}, 8'd1);
        doKon(4'd12, 1'b1);

        // Zero resync at slot 9 reloads keys; coincident kon_req waits a frame
        while (m_idx != 3) opStep(1'b0);
        doKon(4'd2, 1'b0);
        while (m_idx != 9) opStep(1'b0);
        kon_req = 1'b1; kon_ch = 4'd4; kon_val = 1'b1;
        opStep(1'b1);
        checkOutput("resync_slot", {3'b0, slot_I}, 8'd0);
        for (int i = 0; i < 22; i++) opStep(1'b0);
        checkOutput("keyon_s4_late", {7'b0, keyon_I}, 8'd1);

        // Reset between commit and the acknowledge cycle
        wr_req = 1'b1; wr_slot = 5'd3; wr_field = 3'd0; wr_data = 8'hFF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_kills_ack", {7'b0, wr_ack}, 8'd0);
        wr_req = 1'b0;
        resetModel();
        repeat (2) applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_rst_ack", {7'b0, wr_ack}, 8'd0);
        while (m_idx != 3) opStep(1'b0);
        checkFields(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        opStep(1'b0); opStep(1'b0);
        checkFields(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/jtopl_eg_seq.md
# jtopl_eg_seq

Per-slot envelope configuration store and slot sequencer for the OPL envelope generator (jtopl_eg). It holds attack/decay/release/sustain settings for all 18 operator slots, accepts CPU-side writes over a req/ack handshake, and presents the settings of the active slot at EG stage I in step with the operator clock enable. Key-on commands are scheduled so that both slots of a channel switch state in the same frame.

## Interface
Parameters:
- SLOTS, 18, operator slots per frame; slot counter width is 5 bits.
- CHANNELS, 9, channels; channel c owns slots c (modulator) and c+9 (carrier).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cenop  in  1  operator-rate clock enable, one cycle wide
- zero  in  1  slot-0 marker from jtopl_slot_cnt, valid when cenop=1
- wr_req  in  1  write request; held with fields stable until wr_ack
- wr_slot  in  5  target slot 0..17
- wr_field  in  3  0: {arate,drate}; 1: {sl,rrate}; 2: {ksr,en_sus} in bits [1:0]; 3..7 invalid
- wr_data  in  8  write payload; high nibble first named field
- wr_ack  out  1  one-cycle write acknowledge
- wr_err  out  1  one-cycle pulse with wr_ack when slot>=18 or field>=3
- kon_req  in  1  single-cycle key command strobe
- kon_ch  in  4  channel 0..8; values >=9 ignored
- kon_val  in  1  1 key-on, 0 key-off
- slot_I  out  5  slot index currently presented
- arate_I, drate_I, rrate_I, sl_I  out  4 each  envelope rates/level for slot_I
- en_sus_I  out  1  sustain enable for slot_I
- ksr_I  out  1  key-scale-rate for slot_I (user delays one stage to feed ksr_II)
- keyon_I  out  1  effective key state of slot_I's channel

## Operation
- Storage: 18 entries x 18 bits (arate, drate, sl, rrate, en_sus, ksr), all zero at reset.
- Slot counter idx: resets to 17. On cenop: if zero, idx<=0; else idx<=(idx==17)?0:idx+1.
- Output registers load on cenop with the entry of the new idx; slot_I<=new idx; keyon_I<=kon_act[channel(new idx)], channel(i)=i<9?i:i-9.
- Write FSM, states IDLE, ACK:
  - IDLE: if wr_req=1 and cenop=0, commit (write entry if slot/field valid, else flag error), go ACK. If cenop=1, wait.
  - ACK: wr_ack=1 (wr_err as flagged) for exactly this cycle; return IDLE. wr_req sampled again only from IDLE next cycle; requester must drop wr_req in the ACK cycle or a second write is performed.
  - Writes never commit on a cenop cycle, so output loading and storage writes never coincide.
- Key scheduling: kon_pend[8:0] updated on kon_req (valid channel). kon_act[8:0] loads kon_pend on any cenop where the new idx is 0 (frame start, natural wrap or zero resync).
- kon_req in the same cycle as a frame-start load: kon_act takes the pre-update kon_pend; the new value applies next frame.
- Reset mid-operation: all state returns to reset values immediately; a pending write is lost and no wr_ack is produced.

## Timing
- Reset values: wr_ack=0, wr_err=0, slot_I=0, all *_I outputs 0, kon_pend=kon_act=0, FSM IDLE, idx=17.
- First cenop after reset (zero=0) presents slot 0.
- Output latency: *_I valid the cycle after the cenop that selected the slot, stable until the next cenop.
- Write latency: wr_ack one cycle after the commit cycle; commit is the first non-cenop cycle with wr_req=1 in IDLE. Minimum req-to-ack: 1 cycle.
- A write to slot s appears on outputs at the next cenop selecting s after commit.
- Key change: visible on keyon_I from the first frame starting after the kon_req cycle, for both of the channel's slots in the same frame.

## Test plan
- Reset: hold rst_n=0, free-run cenop -> all outputs 0; release, first cenop -> slot_I=0, subsequent cenops 1,2..17,0.
- Write slot 5 field 0 data 0xA3, field 1 data 0x7C, field 2 data 0x03 -> each wr_ack one pulse, wr_err=0; at slot_I=5: arate=A, drate=3, sl=7, rrate=C, ksr=1, en_sus=1; other slots unchanged.
- wr_req asserted in a cenop cycle -> commit deferred one cycle, wr_ack two cycles after assertion; wr_slot=20 -> wr_ack with wr_err=1, storage unchanged.
- kon_req ch 2 val 1 issued while slot_I=6 -> keyon_I stays 0 for slots 2 and 11 this frame; next frame both slot 2 and slot 11 show keyon_I=1.
- Assert zero with cenop while idx=9 -> slot_I=0 next, kon_act reloaded; kon_req coinciding with that cenop -> effect delayed one full frame.
- Drop rst_n between write commit and wr_ack -> no wr_ack, entry reads 0 after reset.
